// File: rtl/multicycle_alu_pkg.sv
// Opcode and state encodings shared by the multicycle ALU and the CPU controller.
package multicycle_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_ITER   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Any opcode with the top bit set is reserved.
  function automatic logic is_illegal(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/multicycle_alu_div_core_16.sv
// Restoring divider on unsigned magnitudes: loads on start, quotient valid 16 edges later.
// No handshake; the caller counts edges. A new start restarts it at any time.
module div_core_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   shifted;
  logic             fits;

  // Partial remainder never reaches the divisor, so WIDTH bits hold it after subtraction.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign fits     = shifted >= {1'b0, dvs};
  assign quotient = quo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (start) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
      cnt <= CW'(WIDTH);
    end else if (cnt != '0) begin
      rem <= fits ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], fits};
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle signed ALU: ADD/SUB/illegal/div-by-zero finish 1 edge after accept, MUL/DIV 17.
// start is only sampled in IDLE; requests while busy are dropped, not queued.
module multicycle_alu
  import multicycle_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t             state, state_nxt;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a_q, b_q, mplr, quotient;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [CW-1:0]      cnt;
  logic               neg, a_neg, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b, simple_res, mag_res;
  logic               accept, iterative, iter_step, div_start;

  assign mag_a     = A[WIDTH-1] ? -A : A;
  assign mag_b     = B[WIDTH-1] ? -B : B;
  assign accept    = (state == ST_IDLE) && start;
  assign iterative = (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
  assign iter_step = ((state == ST_EXEC) && iterative) || ((state == ST_ITER) && (cnt != LAST));
  assign div_start = accept && (opcode == OP_DIV) && (B != '0);
  assign mag_res   = (op == OP_MUL) ? acc[WIDTH-1:0] : quotient;

  div_core_16 #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quotient (quotient)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = iterative ? ST_ITER : ST_FINISH;
      ST_ITER:   if (cnt == LAST) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    done = 1'b0;
    busy = 1'b0;
    case (state)
      ST_IDLE:   busy = 1'b0;
      ST_FINISH: begin done = 1'b1; busy = 1'b1; end
      default:   busy = 1'b1;
    endcase
  end

  // Single-edge results; MUL never lands here and DIV only when the divisor is zero.
  always_comb begin
    simple_res = '0;
    if (!is_illegal(op)) begin
      case (op)
        OP_ADD:  simple_res = a_q + b_q;
        OP_SUB:  simple_res = a_q - b_q;
        OP_DIV:  simple_res = a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        default: simple_res = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      neg    <= 1'b0;
      a_neg  <= 1'b0;
      b_zero <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        op     <= opcode;
        a_q    <= A;
        b_q    <= B;
        neg    <= A[WIDTH-1] ^ B[WIDTH-1];
        a_neg  <= A[WIDTH-1];
        b_zero <= (B == '0);
        cnt    <= '0;
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, mag_a};
        mplr   <= mag_b;
      end
      // The first iteration edge is the EXEC edge, so E1..E16 carry all 16 steps.
      if (iter_step) begin
        cnt <= cnt + CW'(1);
        if (op == OP_MUL) begin
          acc   <= acc + (mplr[0] ? mcand : '0);
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
        end
      end
      if ((state == ST_EXEC) && !iterative) result <= simple_res;
      if ((state == ST_ITER) && (cnt == LAST)) begin
        result <= neg ? -mag_res : mag_res;
        cnt    <= '0;
      end
    end
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; all latencies below are stated for WIDTH=16.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 opcode  input  3  operation select; 000 ADD, 001 SUB, 010 MUL, 011 DIV, 1xx illegal.
REQ-006 A  input  WIDTH  signed operand 1.
REQ-007 B  input  WIDTH  signed operand 2.
REQ-008 result  output  WIDTH  signed result; holds its value until the next completion or reset.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 busy  output  1  high from accept until the done cycle, inclusive.

Function
REQ-011 The block SHALL implement states IDLE, EXEC, ITER and FINISH.
REQ-012 IDLE: start=1 on an edge SHALL latch opcode, A and B, clear done, and go to EXEC (edge E0).
REQ-013 EXEC: ADD, SUB, illegal opcodes and DIV with B=0 SHALL register result at E0+1 and go to FINISH; MUL and DIV with B!=0 SHALL go to ITER.
REQ-014 ITER SHALL run exactly 16 iteration edges (E1..E16) on operand magnitudes, with a 5-bit counter; sign correction and result register load SHALL occur on E17; state then goes to FINISH.
REQ-015 FINISH: done=1 for exactly that one cycle; the next edge SHALL return to IDLE with done=0.
REQ-016 Latency from the start-sampling edge to the done cycle SHALL be 1 edge (ADD/SUB/illegal/div-by-zero) or 17 edges (MUL/DIV).
REQ-017 done SHALL never be high in the cycle immediately after start is sampled, so a requester waiting on done cannot see a stale pulse.
REQ-018 ADD/SUB SHALL be two's-complement modulo 2^16, with no overflow flag.
REQ-019 MUL SHALL be iterative shift-add on magnitudes; result = low 16 bits of the signed 32-bit product.
REQ-020 DIV SHALL be restoring division on magnitudes; quotient truncated toward zero; result = quotient.
REQ-021 DIV by zero: result = 16'h7FFF if A>=0, else 16'h8000.
REQ-022 DIV -32768/-1: result = -32768 (wraps).
REQ-023 Illegal opcode: result = 0.
REQ-024 start while busy SHALL be ignored; it is neither queued nor does it alter the latched operands.
REQ-025 start held high through FINISH SHALL be accepted again in the following IDLE cycle (back-to-back ops, one idle cycle between done pulses).
REQ-026 Operand inputs SHALL NOT be required stable after E0.

Reset
REQ-027 reset SHALL immediately force state=IDLE, result=0, done=0, busy=0, counter=0, and clear the internal accumulator, quotient and remainder registers.
REQ-028 reset during EXEC/ITER/FINISH SHALL abort the operation with no done pulse; the first start after deassertion SHALL be serviced normally.

Structure
REQ-029 Opcode localparams (ADD, SUB, MUL, DIV) and state encodings SHALL live in a shared package/include also used by the CPU controller.
REQ-030 The iterative magnitude divider SHALL be the one sub-module, div_core_16 (start, magnitudes in, quotient out, 16-edge fixed latency); multiply stays inline.

Verification
REQ-031 ADD A=100, B=-200 -> done 1 edge after start, result=-100; SUB A=32767, B=-1 -> result=-32768.
REQ-032 MUL A=-123, B=45 -> done at edge 17, result=-5535; MUL 300*300 -> result=24464.
REQ-033 DIV A=-7, B=2 -> result=-3 at edge 17; DIV 5/0 -> result=32767 at edge 1; DIV -32768/-1 -> result=-32768.
REQ-034 MUL 3*4 with a second start (ADD 1+1) pulsed at edge 5 -> single done at edge 17, result=12, second request ignored.
REQ-035 Reset asserted at edge 8 of a MUL -> done never pulses, result=0; a subsequent ADD 2+3 -> result=5 after 1 edge.
REQ-036 opcode=3'b110 -> done after 1 edge, result=0; a done pulse is exactly 1 cycle wide in every test.
